// File: rtl/rv32_pkg.sv
// rv32_pkg: shared widths, one-hot instruction bit indices and ALU op-group masks.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int NUM_INSTR = 37;
  localparam int IDX_LUI = 0, IDX_AUIPC = 1, IDX_JAL = 2, IDX_JALR = 3;
  localparam int IDX_BEQ = 4, IDX_BNE = 5, IDX_BLT = 6, IDX_BGE = 7, IDX_BLTU = 8, IDX_BGEU = 9;
  localparam int IDX_LB = 10, IDX_LH = 11, IDX_LW = 12, IDX_LBU = 13, IDX_LHU = 14;
  localparam int IDX_SB = 15, IDX_SH = 16, IDX_SW = 17;
  localparam int IDX_ADDI = 18, IDX_SLTI = 19, IDX_SLTIU = 20, IDX_XORI = 21, IDX_ORI = 22, IDX_ANDI = 23;
  localparam int IDX_SLLI = 24, IDX_SRLI = 25, IDX_SRAI = 26;
  localparam int IDX_ADD = 27, IDX_SUB = 28, IDX_SLL = 29, IDX_SLT = 30, IDX_SLTU = 31;
  localparam int IDX_XOR = 32, IDX_SRL = 33, IDX_SRA = 34, IDX_OR = 35, IDX_AND = 36;
  typedef logic [NUM_INSTR-1:0] instr_t;
  function automatic instr_t bit_of(int i);
    return instr_t'(1) << i;
  endfunction
  localparam instr_t M_ADD = bit_of(IDX_AUIPC) | bit_of(IDX_JAL) | bit_of(IDX_LB) | bit_of(IDX_LH)
    | bit_of(IDX_LW) | bit_of(IDX_LBU) | bit_of(IDX_LHU) | bit_of(IDX_SB) | bit_of(IDX_SH)
    | bit_of(IDX_SW) | bit_of(IDX_ADDI) | bit_of(IDX_ADD);
  localparam instr_t M_LT = bit_of(IDX_BLT) | bit_of(IDX_SLTI) | bit_of(IDX_SLT);
  localparam instr_t M_LTU = bit_of(IDX_BLTU) | bit_of(IDX_SLTIU) | bit_of(IDX_SLTU);
  localparam instr_t M_XOR = bit_of(IDX_XORI) | bit_of(IDX_XOR);
  localparam instr_t M_OR = bit_of(IDX_ORI) | bit_of(IDX_OR);
  localparam instr_t M_AND = bit_of(IDX_ANDI) | bit_of(IDX_AND);
  localparam instr_t M_SLL = bit_of(IDX_SLLI) | bit_of(IDX_SLL);
  localparam instr_t M_SRL = bit_of(IDX_SRLI) | bit_of(IDX_SRL);
  localparam instr_t M_SRA = bit_of(IDX_SRAI) | bit_of(IDX_SRA);
endpackage

// File: rtl/rv32_alu_if.sv
// rv32_alu_if: operand/instruction inputs and registered result of the execute-stage ALU.
interface rv32_alu_if;
  import rv32_pkg::*;
  logic [XLEN-1:0] v1;
  logic [XLEN-1:0] v2;
  instr_t instructions;
  logic [XLEN-1:0] ALUoutput;
  logic alu_valid;
  modport master (output v1, v2, instructions, input ALUoutput, alu_valid);
  modport slave (input v1, v2, instructions, output ALUoutput, alu_valid);
endinterface

// File: rtl/rv32_alu_comb.sv
// rv32_alu_comb: next ALU result from operands and one-hot instruction; lowest set bit wins.
module rv32_alu_comb
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] v1_i,
  input  logic [XLEN-1:0] v2_i,
  input  instr_t          instr_i,
  output logic [XLEN-1:0] res_o
);
  logic [XLEN-1:0] sum, diff, sll, srl, sra;
  logic [4:0] sh;
  logic lts, ltu, eq;
  assign sh = v2_i[4:0];
  assign sum = v1_i + v2_i;
  assign diff = v1_i - v2_i;
  assign sll = v1_i << sh;
  assign srl = v1_i >> sh;
  assign sra = $unsigned($signed(v1_i) >>> sh);
  assign lts = $signed(v1_i) < $signed(v2_i);
  assign ltu = v1_i < v2_i;
  assign eq = v1_i == v2_i;
  // Walk from the top so the lowest-index set bit is assigned last and takes priority.
  always_comb begin
    res_o = '0;
    for (int i = NUM_INSTR - 1; i >= 0; i--)
      if (instr_i[i])
        res_o = (i == IDX_LUI) ? v2_i :
                M_ADD[i] ? sum :
                (i == IDX_JALR) ? {sum[XLEN-1:1], 1'b0} :
                (i == IDX_BEQ) ? XLEN'(eq) :
                (i == IDX_BNE) ? XLEN'(!eq) :
                M_LT[i] ? XLEN'(lts) :
                (i == IDX_BGE) ? XLEN'(!lts) :
                M_LTU[i] ? XLEN'(ltu) :
                (i == IDX_BGEU) ? XLEN'(!ltu) :
                M_XOR[i] ? v1_i ^ v2_i :
                M_OR[i] ? v1_i | v2_i :
                M_AND[i] ? v1_i & v2_i :
                M_SLL[i] ? sll :
                M_SRL[i] ? srl :
                M_SRA[i] ? sra :
                (i == IDX_SUB) ? diff : '0;
  end
endmodule

// File: rtl/rv32_alu.sv
// rv32_alu: single-cycle-latency RV32I ALU; registers the combinational result and a valid flag.
module rv32_alu
  import rv32_pkg::*;
(
  input logic clk,
  input logic rst,
  rv32_alu_if.slave bus
);
  logic [XLEN-1:0] alu_d, alu_q;
  logic valid_q;
  rv32_alu_comb u_comb (
    .v1_i    (bus.v1),
    .v2_i    (bus.v2),
    .instr_i (bus.instructions),
    .res_o   (alu_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      valid_q <= |bus.instructions;
    end
  end
  assign bus.ALUoutput = alu_q;
  assign bus.alu_valid = valid_q;
endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: directed-vector bench for rv32_alu with hand-computed expected results.
module tb_rv32_alu;
  import rv32_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  rv32_alu_if bus ();
  rv32_alu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input instr_t ins, input logic [31:0] a, input logic [31:0] b);
    bus.instructions = ins;
    bus.v1 = a;
    bus.v2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(bit_of(IDX_ADD), 32'd5, 32'd4);
      total++; if (bus.ALUoutput !== 32'd0) $display("FAIL reset_out cyc%0d got=%h exp=%h", c, bus.ALUoutput, 32'd0); else passed++;
      total++; if (bus.alu_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got=%b exp=0", c, bus.alu_valid); else passed++;
    end
    rst = 1'b0;
    step(bit_of(IDX_ADD), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd9) $display("FAIL release_out got=%h exp=%h", bus.ALUoutput, 32'd9); else passed++;
    total++; if (bus.alu_valid !== 1'b1) $display("FAIL release_valid got=%b exp=1", bus.alu_valid); else passed++;
  endtask

  task automatic test_sweep();
    logic [31:0] exp_tab [NUM_INSTR] = '{
      32'd4, 32'd9, 32'd9, 32'd8, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1,
      32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd0,
      32'd0, 32'd1, 32'd5, 32'd4, 32'h50, 32'd0, 32'd0, 32'd9, 32'd1, 32'h50,
      32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd5, 32'd4};
    for (int i = 0; i < NUM_INSTR; i++) begin
      step(bit_of(i), 32'd5, 32'd4);
      total++; if (bus.ALUoutput !== exp_tab[i]) $display("FAIL sweep_bit%0d got=%h exp=%h", i, bus.ALUoutput, exp_tab[i]); else passed++;
      total++; if (bus.alu_valid !== 1'b1) $display("FAIL sweep_valid_bit%0d got=%b exp=1", i, bus.alu_valid); else passed++;
    end
    step('0, 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd0) $display("FAIL zero_vec_out got=%h exp=%h", bus.ALUoutput, 32'd0); else passed++;
    total++; if (bus.alu_valid !== 1'b0) $display("FAIL zero_vec_valid got=%b exp=0", bus.alu_valid); else passed++;
  endtask

  task automatic test_signed();
    int idx [8] = '{IDX_SLT, IDX_SLTU, IDX_BLT, IDX_BLTU, IDX_BGE, IDX_BGEU, IDX_SRA, IDX_SRL};
    logic [31:0] ex [8] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h0FFFFFFF};
    for (int i = 0; i < 8; i++) begin
      step(bit_of(idx[i]), 32'hFFFFFFFB, 32'd4);
      total++; if (bus.ALUoutput !== ex[i]) $display("FAIL signed_bit%0d got=%h exp=%h", idx[i], bus.ALUoutput, ex[i]); else passed++;
    end
  endtask

  task automatic test_wrap();
    step(bit_of(IDX_ADD), 32'hFFFFFFFF, 32'd1);
    total++; if (bus.ALUoutput !== 32'd0) $display("FAIL wrap_add got=%h exp=%h", bus.ALUoutput, 32'd0); else passed++;
    step(bit_of(IDX_SUB), 32'hFFFFFFFF, 32'd1);
    total++; if (bus.ALUoutput !== 32'hFFFFFFFE) $display("FAIL wrap_sub got=%h exp=%h", bus.ALUoutput, 32'hFFFFFFFE); else passed++;
    step(bit_of(IDX_SLL), 32'd1, 32'h21);
    total++; if (bus.ALUoutput !== 32'd2) $display("FAIL shamt_mask got=%h exp=%h", bus.ALUoutput, 32'd2); else passed++;
  endtask

  task automatic test_priority();
    step(bit_of(IDX_ADD) | bit_of(IDX_SUB), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd9) $display("FAIL priority_out got=%h exp=%h", bus.ALUoutput, 32'd9); else passed++;
    total++; if (bus.alu_valid !== 1'b1) $display("FAIL priority_valid got=%b exp=1", bus.alu_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    step(bit_of(IDX_ADD), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd9) $display("FAIL b2b_add got=%h exp=%h", bus.ALUoutput, 32'd9); else passed++;
    step(bit_of(IDX_SUB), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd1) $display("FAIL b2b_sub got=%h exp=%h", bus.ALUoutput, 32'd1); else passed++;
    step(bit_of(IDX_XOR), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd1) $display("FAIL b2b_xor got=%h exp=%h", bus.ALUoutput, 32'd1); else passed++;
    rst = 1'b1;
    step(bit_of(IDX_ADD), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd0) $display("FAIL b2b_rst_out got=%h exp=%h", bus.ALUoutput, 32'd0); else passed++;
    total++; if (bus.alu_valid !== 1'b0) $display("FAIL b2b_rst_valid got=%b exp=0", bus.alu_valid); else passed++;
    rst = 1'b0;
    step(bit_of(IDX_OR), 32'd5, 32'd4);
    total++; if (bus.ALUoutput !== 32'd5) $display("FAIL b2b_resume_or got=%h exp=%h", bus.ALUoutput, 32'd5); else passed++;
    total++; if (bus.alu_valid !== 1'b1) $display("FAIL b2b_resume_valid got=%b exp=1", bus.alu_valid); else passed++;
  endtask

  initial begin
    bus.instructions = '0;
    bus.v1 = '0;
    bus.v2 = '0;
    test_reset();
    test_sweep();
    test_signed();
    test_wrap();
    test_priority();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
